clk_div_bank: RTL

//   N-channel clock-enable/divider bank. Derives N_CH square-wave outputs from CLK100MHZ.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_chan.sv | 79 +++++++
 rtl/clk_div_bank.sv | 79 +++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: default counter width and
// divisor values for the common output frequencies from a 100 MHz clock.
package clk_div_pkg;

  localparam int DIV_W_DEFAULT = 27;

  // Divisor = output period in 100 MHz cycles
  localparam int unsigned DIV_50MHZ  = 2;
  localparam int unsigned DIV_10MHZ  = 10;
  localparam int unsigned DIV_1MHZ   = 100;
  localparam int unsigned DIV_100KHZ = 1_000;
  localparam int unsigned DIV_10KHZ  = 10_000;
  localparam int unsigned DIV_1KHZ   = 100_000;
  localparam int unsigned DIV_100HZ  = 1_000_000;
  localparam int unsigned DIV_10HZ   = 10_000_000;
  localparam int unsigned DIV_1HZ    = 100_000_000;

  // Smallest divisor that still yields a square wave (one high, one low cycle)
  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor and registered output.
// Optional tick output is built only when CLK_DIV_TICK_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DIV_DEFAULT = DIV_1KHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             clk_out
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  logic [DIV_W-1:0] ctr;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic [DIV_W-1:0] ctr_inc;
  logic             wrap;

  assign ctr_inc = ctr + 1'b1;
  assign wrap    = sync || (ctr == div_act - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr      <= DIV_W'(DIV_DEFAULT - 1);
      div_act  <= DIV_W'(DIV_DEFAULT);
      div_pend <= DIV_W'(DIV_DEFAULT);
      pending  <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      if (!en) begin
        // Idle channel parks at the last count so enabling rises immediately
        clk_out <= 1'b0;
        if (pending) begin
          div_act <= div_pend;
          ctr     <= div_pend - 1'b1;
          pending <= 1'b0;
        end else begin
          ctr <= div_act - 1'b1;
        end
      end else if (wrap) begin
        ctr     <= '0;
        clk_out <= 1'b1;
        if (pending) begin
          div_act <= div_pend;
          pending <= 1'b0;
        end
      end else begin
        ctr     <= ctr_inc;
        clk_out <= (ctr_inc < (div_act >> 1));
      end
      // A load is only offered while nothing is pending, so it never races an apply
      if (load && !pending) begin
        div_pend <= load_div;
        pending  <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_TICK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= en && wrap;
    end
  end
`endif

endmodule

// File: rtl/clk_div_bank.sv
// N-channel runtime-programmable clock divider bank with a valid/ready config port.
// Define CLK_DIV_TICK_EN to add the per-channel tick_out clock-enable pulses.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DIV_DEFAULT = DIV_1KHZ,
  localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   clk_out
`ifdef CLK_DIV_TICK_EN
  ,
  output logic [N_CH-1:0]   tick_out
`endif
);

  // Handshake: a load transfers in any cycle where cfg_valid && cfg_ready.
  // Requests to a channel still holding a pending divisor are stalled;
  // requests to a nonexistent channel are always accepted (and rejected).
  logic chan_ok;
  logic div_ok;
  logic accept;
  logic legal;

  always_comb begin
    chan_ok   = int'(cfg_chan) < N_CH;
    div_ok    = cfg_div >= DIV_W'(DIV_MIN);
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_chan == CH_W'(i)) cfg_ready = !pending[i];
    end
  end

  assign accept = cfg_valid && cfg_ready;
  assign legal  = chan_ok && div_ok;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && !legal;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    logic load;
    assign load = accept && legal && (cfg_chan == CH_W'(g));

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .clk      (CLK100MHZ),
      .rst      (RST),
      .en       (en[g]),
      .sync     (sync),
      .load     (load),
      .load_div (cfg_div),
      .pending  (pending[g]),
      .clk_out  (clk_out[g])
`ifdef CLK_DIV_TICK_EN
      ,
      .tick     (tick_out[g])
`endif
    );
  end

endmodule
